// File: rtl/oled_spi_writer.sv
// Byte-wide SPI write engine for an SSD1331-class OLED panel: one byte plus a
// command/data flag per WRITE_START/WRITE_DONE request, shifted out MSB first.
module oled_spi_writer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       WRITE_START,
    input  logic [7:0] DATA,
    input  logic       DC_IN,
    output logic       WRITE_DONE,
    output logic       BUSY,
    output logic       OLED_SCLK,
    output logic       OLED_MOSI,
    output logic       OLED_CS_N,
    output logic       OLED_DC,
    output logic [2:0] DBG_STATE
);

    // Handshake: WRITE_START is a level request held until WRITE_DONE; a request
    // is taken only in IDLE while armed, and armed needs WRITE_START seen low
    // since the last DONE, so a start held across WRITE_DONE never re-triggers.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic        phase_high_q, phase_high_d;
    logic [7:0]  shift_q, shift_d;
    logic        dc_q, dc_d;
    logic        armed_q, armed_d;

    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        cnt_last;
    logic        frame_d;

    assign cnt_last = (cnt_q == 16'd0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        phase_high_d = phase_high_q;
        shift_d      = shift_q;
        dc_d         = dc_q;

        case (state_q)
            S_IDLE: begin
                if (WRITE_START && armed_q) begin
                    state_d = S_SETUP;
                    cnt_d   = DIV_M1;
                    shift_d = DATA;
                    dc_d    = DC_IN;
                end
            end
            S_SETUP: begin
                if (cnt_last) begin
                    state_d      = S_SHIFT;
                    cnt_d        = DIV_M1;
                    bit_d        = 3'd7;
                    phase_high_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_SHIFT: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d = DIV_M1;
                    if (!phase_high_q) begin
                        phase_high_d = 1'b1;
                    end else if (bit_q == 3'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        // Next bit goes onto MOSI only as the new low phase starts.
                        bit_d        = bit_q - 3'd1;
                        phase_high_d = 1'b0;
                        shift_d      = {shift_q[6:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                if (cnt_last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        armed_d = armed_q;
        if (state_q == S_HOLD && cnt_last) begin
            armed_d = 1'b0;
        end else if (!WRITE_START) begin
            armed_d = 1'b1;
        end
    end

    // Pin values are registered from the next state so the panel never sees
    // decode glitches; they line up cycle-for-cycle with the state register.
    always_comb begin
        frame_d = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        sclk_d  = !((state_d == S_SHIFT) && !phase_high_d);
        mosi_d  = frame_d && shift_d[7];
        cs_n_d  = !frame_d;
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            bit_q        <= 3'd0;
            phase_high_q <= 1'b0;
            shift_q      <= 8'd0;
            dc_q         <= 1'b0;
            armed_q      <= 1'b1;
            sclk_q       <= 1'b1;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            phase_high_q <= phase_high_d;
            shift_q      <= shift_d;
            dc_q         <= dc_d;
            armed_q      <= armed_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            cs_n_q       <= cs_n_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign WRITE_DONE = done_q;
    assign BUSY       = busy_q;
    assign OLED_SCLK  = sclk_q;
    assign OLED_MOSI  = mosi_q;
    assign OLED_CS_N  = cs_n_q;
    assign OLED_DC    = dc_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_oled_spi_writer.sv
// Bench for oled_spi_writer: two instances (CLK_DIV=4 and CLK_DIV=1) checked
// cycle by cycle against a waveform model and a byte-level scoreboard.
module tb_oled_spi_writer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start0 = 1'b0, dcin0 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic       start1 = 1'b0, dcin1 = 1'b0;
  logic [7:0] data1 = 8'h00;

  logic       done0, busy0, sclk0, mosi0, cs0, dco0;
  logic       done1, busy1, sclk1, mosi1, cs1, dco1;
  logic [2:0] dbg0, dbg1;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       dc;
    int         drop_at;
    logic [7:0] late;
    logic [7:0] exp_bits;
    int         exp_done;
  } vec_t;

  vec_t vecs[4];

  oled_spi_writer #(.CLK_DIV(4)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .WRITE_START(start0), .DATA(data0), .DC_IN(dcin0),
    .WRITE_DONE(done0), .BUSY(busy0), .OLED_SCLK(sclk0), .OLED_MOSI(mosi0),
    .OLED_CS_N(cs0), .OLED_DC(dco0), .DBG_STATE(dbg0)
  );

  oled_spi_writer #(.CLK_DIV(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .WRITE_START(start1), .DATA(data1), .DC_IN(dcin1),
    .WRITE_DONE(done1), .BUSY(busy1), .OLED_SCLK(sclk1), .OLED_MOSI(mosi1),
    .OLED_CS_N(cs1), .OLED_DC(dco1), .DBG_STATE(dbg1)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, expected finish");
    n_errors++;
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {done, busy, sclk, mosi, cs_n, dc}
  function automatic logic [5:0] get_out(input int sel);
    if (sel == 0) return {done0, busy0, sclk0, mosi0, cs0, dco0};
    return {done1, busy1, sclk1, mosi1, cs1, dco1};
  endfunction

  task automatic drive(input int sel, input logic st, input logic [7:0] d, input logic dc);
    if (sel == 0) begin
      start0 = st; data0 = d; dcin0 = dc;
    end else begin
      start1 = st; data1 = d; dcin1 = dc;
    end
  endtask

  // Expected pins n cycles after the accept edge, from the timing rules:
  // CS low for 18*div cycles, bit k rises at 2k*div, bit k+1 appears at (2k+1)*div.
  function automatic logic [5:0] model(input int n, input logic [7:0] d, input logic dc,
                                       input int div);
    int   k;
    logic sclk, mosi;
    if (n < 18 * div) begin
      sclk = 1'b1;
      if (n >= div && n < 17 * div && ((n - div) / div) % 2 == 0) sclk = 1'b0;
      if (n < div) k = 1;
      else begin
        k = (n - div) / (2 * div) + 1;
        if (k > 8) k = 8;
      end
      mosi = d[8 - k];
      return {1'b0, 1'b1, sclk, mosi, 1'b0, dc};
    end else if (n == 18 * div) begin
      return {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, dc};
    end
    return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, dc};
  endfunction

  // Raise start now; the next edge is the accept edge. Drops start in the DONE
  // cycle, so a following call gets accepted 2 cycles after WRITE_DONE rises.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic dc,
                            input int drop_at, input logic [7:0] late,
                            input logic [7:0] exp_bits, input int exp_done);
    int         div;
    int         done_at;
    logic       prev_sclk;
    logic [7:0] got;
    logic [5:0] out, e;
    div = (sel == 0) ? 4 : 1;
    if (sel == 0) exp_q.push_back({dc, d});
    drive(sel, 1'b1, d, dc);
    done_at = -1;
    prev_sclk = 1'b1;
    got = 8'h00;
    for (int n = 0; n <= 18 * div + 1; n++) begin
      tick();
      out = get_out(sel);
      e = model(n, d, dc, div);
      if (e[1]) out[0] = e[0];
      check($sformatf("pins dut%0d data=%0h n=%0d", sel, d, n), 32'(out), 32'(e));
      if (!prev_sclk && out[3]) got = {got[6:0], out[2]};
      prev_sclk = out[3];
      if (out[5] && done_at < 0) done_at = n;
      if (n == drop_at) drive(sel, 1'b0, late, ~dc);
      if (n == 18 * div) drive(sel, 1'b0, d, dc);
    end
    check($sformatf("bits dut%0d data=%0h", sel, d), 32'(got), 32'(exp_bits));
    check($sformatf("done_at dut%0d data=%0h", sel, d), 32'(done_at), 32'(exp_done));
  endtask

  // ---------------- scoreboard on dut0 ----------------
  logic [7:0] sb_bits = 8'h00;
  int         sb_n = 0;
  logic       sb_dc = 1'b0;
  logic       sb_prev = 1'b1;

  always begin
    @(posedge CLK);
    #2;
    if (RST_N && done0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_done: got WRITE_DONE with no pending byte");
      end else begin
        check("sb_byte", 32'({sb_dc, sb_bits}), 32'(exp_q.pop_front()));
        check("sb_nbits", 32'(sb_n), 32'd8);
      end
    end
    if (!RST_N || cs0) begin
      sb_n = 0;
    end else if (!sb_prev && sclk0) begin
      sb_bits = {sb_bits[6:0], mosi0};
      sb_dc = dco0;
      sb_n++;
    end
    sb_prev = sclk0;
  end

  // ---------------- stimulus ----------------
  initial begin
    int         dones;
    int         got_done;
    int         sel, div, drop;
    logic [7:0] d, late;
    logic       dc;

    vecs[0] = '{0, 8'hAE, 1'b0, -1, 8'h00, 8'hAE, 72};
    vecs[1] = '{0, 8'h87, 1'b0, 20, 8'h00, 8'h87, 72};
    vecs[2] = '{1, 8'h06, 1'b0, -1, 8'h00, 8'h06, 18};
    vecs[3] = '{1, 8'hA5, 1'b1, 5, 8'h5A, 8'hA5, 18};

    // reset with a live request on both inputs
    drive(0, 1'b1, 8'hFF, 1'b1);
    drive(1, 1'b1, 8'hFF, 1'b1);
    repeat (3) tick();
    check("reset_pins_dut0", 32'(get_out(0)), 32'b001010);
    check("reset_pins_dut1", 32'(get_out(1)), 32'b001010);
    check("reset_state_dut0", 32'(dbg0), 32'd0);
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    RST_N = 1'b1;
    repeat (2) tick();

    // reset in the middle of a byte
    drive(0, 1'b1, 8'h3C, 1'b1);
    repeat (30) tick();
    check("midreset_cs_before", 32'(cs0), 32'd0);
    RST_N = 1'b0;
    #1;
    check("midreset_pins_async", 32'(get_out(0)), 32'b001010);
    drive(0, 1'b0, 8'h00, 1'b0);
    repeat (2) tick();
    RST_N = 1'b1;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done0) dones++;
    end
    check("midreset_no_done", 32'(dones), 32'd0);

    for (int v = 0; v < 4; v++)
      send_frame(vecs[v].sel, vecs[v].data, vecs[v].dc, vecs[v].drop_at, vecs[v].late,
                 vecs[v].exp_bits, vecs[v].exp_done);

    // back-to-back sequencer handshake
    send_frame(0, 8'h81, 1'b0, -1, 8'h00, 8'h81, 72);
    send_frame(0, 8'hFF, 1'b1, -1, 8'h00, 8'hFF, 72);

    // start held high: exactly one transfer until start toggles
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'h55});
    drive(0, 1'b1, 8'h55, 1'b0);
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done0) dones++;
    end
    check("norearm_dones", 32'(dones), 32'd1);
    check("norearm_idle_busy", 32'(busy0), 32'd0);
    drive(0, 1'b0, 8'h55, 1'b0);
    tick();
    drive(0, 1'b1, 8'h55, 1'b0);
    tick();
    check("rearm_accept_busy", 32'(busy0), 32'd1);
    got_done = 0;
    for (int i = 0; i < 100 && got_done == 0; i++) begin
      tick();
      if (done0) got_done = 1;
    end
    check("rearm_done_seen", 32'(got_done), 32'd1);
    drive(0, 1'b0, 8'h00, 1'b0);
    repeat (2) tick();

    // randomized frames on both dividers
    for (int r = 0; r < 16; r++) begin
      sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
      div = (sel == 0) ? 4 : 1;
      d = 8'($urandom);
      late = 8'($urandom);
      dc = 1'($urandom);
      drop = -1;
      if ($urandom_range(0, 1) == 1) drop = $urandom_range(0, 18 * div - 1);
      repeat ($urandom_range(0, 3)) tick();
      send_frame(sel, d, dc, drop, late, d, 18 * div);
    end

    repeat (5) tick();
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
